// File: rtl/i2s_tx.sv
// i2s_tx: serializes mono samples as a standard I2S stream (BCLK, LRCLK, SD) from the DSP clock.
// Build option I2S_TX_UNDERRUN_MUTE_EN: send a silent frame on underrun instead of repeating the last sample.
module i2s_tx #(
    parameter int unsigned PKT_WIDTH  = 16,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [PKT_WIDTH-1:0] pkt_i,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    output logic                        bclk_o,
    output logic                        lrclk_o,
    output logic                        sd_o,
    output logic                        underrun_o
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_IDX_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [PKT_WIDTH-1:0]  hold;
    logic [PKT_WIDTH-1:0]  shadow;
    logic                  hold_full;

    logic                  div_tc;
    logic                  fall_evt;
    logic                  bit_wrap;
    logic                  frame_start;
    logic                  accept;
    logic [BIT_W-1:0]      bit_nxt;
    logic [BIT_W-1:0]      slot_pos;
    logic [SLOT_IDX_W-1:0] slot_idx;
    logic                  lrclk_nxt;
    logic                  sd_nxt;
    logic [PKT_WIDTH-1:0]  shadow_nxt;
    logic [SLOT_WIDTH-1:0] slot_bits;

    assign hold_full = !pkt_ready_o;

    // Divider / bit-counter decode and the shadow value seen by this fall event
    always_comb begin
        div_tc      = (div_cnt == DIV_LAST);
        fall_evt    = div_tc && bclk_o;
        bit_wrap    = (bit_cnt == BIT_LAST);
        bit_nxt     = bit_wrap ? '0 : bit_cnt + BIT_W'(1);
        frame_start = fall_evt && bit_wrap;
        accept      = pkt_valid_i && pkt_ready_o;
        lrclk_nxt   = (bit_nxt >= SLOT_LEN);
        slot_pos    = lrclk_nxt ? (bit_nxt - SLOT_LEN) : bit_nxt;
        slot_idx    = SLOT_IDX_W'(slot_pos);

        shadow_nxt = shadow;
        if (frame_start) begin
            if (hold_full) begin
                shadow_nxt = hold;
            end
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            else begin
                shadow_nxt = '0;
            end
`endif
        end
    end

    // Slot bit map: position 0 is the one-BCLK I2S delay, MSB goes out at position 1
    for (genvar p = 0; p < SLOT_WIDTH; p++) begin : g_slot
        if ((p >= 1) && (p <= PKT_WIDTH)) begin : g_data
            assign slot_bits[p] = shadow_nxt[PKT_WIDTH-p];
        end else begin : g_pad
            assign slot_bits[p] = 1'b0;
        end
    end

    assign sd_nxt = slot_bits[slot_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_LAST;
            bclk_o      <= 1'b0;
            lrclk_o     <= 1'b0;
            sd_o        <= 1'b0;
            underrun_o  <= 1'b0;
            pkt_ready_o <= 1'b1;
            hold        <= '0;
            shadow      <= '0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                bclk_o  <= !bclk_o;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            underrun_o <= frame_start && !hold_full;

            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                lrclk_o <= lrclk_nxt;
                sd_o    <= sd_nxt;
                shadow  <= shadow_nxt;
            end

            // Accept and frame-start load are exclusive: accept needs an empty hold
            if (frame_start && hold_full) begin
                pkt_ready_o <= 1'b1;
            end else if (accept) begin
                hold        <= pkt_i;
                pkt_ready_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx (BCLK_DIV=2 main instance, BCLK_DIV=1 secondary instance).
module tb_i2s_tx;

    localparam int FB = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt0 = '0;
    logic [15:0] pkt1 = '0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        rdy0, bclk0, lr0, sd0, ur0;
    logic        rdy1, bclk1, lr1, sd1, ur1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2s_tx #(.PKT_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .pkt_i(pkt0), .pkt_valid_i(v0), .pkt_ready_o(rdy0),
        .bclk_o(bclk0), .lrclk_o(lr0), .sd_o(sd0), .underrun_o(ur0)
    );

    i2s_tx #(.PKT_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .pkt_i(pkt1), .pkt_valid_i(v1), .pkt_ready_o(rdy1),
        .bclk_o(bclk1), .lrclk_o(lr1), .sd_o(sd1), .underrun_o(ur1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected SD bits of one frame indexed by bit_cnt value k
    function automatic logic [63:0] frame_bits(input logic [15:0] s);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < FB; k++) begin
            int p;
            p = k % 32;
            if (p >= 1 && p <= 16) f[k] = s[16-p];
        end
        return f;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard / monitor state for the BCLK_DIV=2 instance
    logic [15:0] exp_q[$];
    logic [15:0] model_shadow = '0;
    logic [63:0] cap_sd = '0;
    logic [63:0] cap_lr = '0;
    int rise_n = 0, mon_k = -1, frames_done = 0, exp_underruns = 0;
    int ur_pulses = 0, ur_hi = 0, cyc = 0, last_b = -1, last_l = -1, bclk_per = 0, lr_per = 0;
    logic bprev = 1'b0, lprev = 1'b0, urprev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rise_n = 0; mon_k = -1; model_shadow = '0;
                bprev = 1'b0; lprev = 1'b0; urprev = 1'b0;
                cyc = 0; last_b = -1; last_l = -1;
            end else begin
                cyc++;
                if (ur0) ur_hi++;
                if (ur0 && !urprev) ur_pulses++;
                if (lr0 && !lprev) begin
                    if (last_l >= 0) lr_per = cyc - last_l;
                    last_l = cyc;
                end
                if (bclk0 && !bprev) begin
                    if (last_b >= 0) bclk_per = cyc - last_b;
                    last_b = cyc;
                    rise_n++;
                    if (rise_n >= 2) begin
                        mon_k = (rise_n - 2) % FB;
                        if (mon_k == 0) begin
                            cap_sd = '0;
                            cap_lr = '0;
                            if (exp_q.size() > 0) begin
                                model_shadow = exp_q.pop_front();
                            end else begin
                                exp_underruns++;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                                model_shadow = '0;
`endif
                            end
                        end
                        cap_sd[mon_k] = sd0;
                        cap_lr[mon_k] = lr0;
                        if (mon_k == FB - 1) begin
                            check_eq("frame_sd", cap_sd, frame_bits(model_shadow));
                            check_eq("frame_lrclk", cap_lr, {32'hFFFF_FFFF, 32'h0000_0000});
                            frames_done++;
                        end
                    end
                end
                bprev = bclk0;
                lprev = lr0;
                urprev = ur0;
            end
        end
    end

    task automatic wait_pos(input int f, input int k, input int budget);
        int c;
        c = 0;
        while (!(frames_done == f && mon_k == k) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) check_eq("wait_pos", {frames_done, mon_k}, {f, k});
    endtask

    task automatic check_reset0(input string tag);
        check_eq({tag, "_bclk"}, bclk0, 1'b0);
        check_eq({tag, "_lrclk"}, lr0, 1'b0);
        check_eq({tag, "_sd"}, sd0, 1'b0);
        check_eq({tag, "_underrun"}, ur0, 1'b0);
        check_eq({tag, "_ready"}, rdy0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_lr, prev_rdy, found, b1prev;
        logic [63:0] c1_sd, c1_lr;
        int n1, bits1, lr1_last, lr1_per;

        repeat (3) tick();
        check_reset0("rst");
        check_eq("rst1_ready", rdy1, 1'b1);
        check_eq("rst1_bclk", bclk1, 1'b0);

        // Sample accepted before the first frame start
        rst = 1'b0; pkt0 = 16'hA5C3; v0 = 1'b1; exp_q.push_back(16'hA5C3);
        tick(); v0 = 1'b0;
        check_eq("acc_ready", rdy0, 1'b0);
        check_eq("bclk_e1", bclk0, 1'b0);
        tick(); check_eq("bclk_e2", bclk0, 1'b1);
        tick(); check_eq("bclk_e3", bclk0, 1'b1);
        tick(); check_eq("bclk_e4", bclk0, 1'b0);
        check_eq("ready_e4", rdy0, 1'b1);
        check_eq("underrun_e4", ur0, 1'b0);
        check_eq("lrclk_e4", lr0, 1'b0);

        // Frame 1 carries A5C3, frame 2 underruns
        wait_pos(2, 63, 700);
        check_eq("bclk_period", bclk_per, 4);
        check_eq("lrclk_period", lr_per, 256);
        check_eq("underrun_pulses_f2", ur_pulses, exp_underruns);
        check_eq("underrun_cycles_f2", ur_hi, exp_underruns);

        // Back-to-back samples: second one ignored while hold is full
        wait_pos(2, 20, 300);
        pkt0 = 16'h1234; v0 = 1'b1; exp_q.push_back(16'h1234);
        tick();
        check_eq("b2b_ready", rdy0, 1'b0);
        pkt0 = 16'h5678;
        repeat (5) tick();
        check_eq("b2b_busy", rdy0, 1'b0);
        v0 = 1'b0;
        prev_lr = lr0; prev_rdy = rdy0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (prev_lr && !lr0) found = 1'b1;
            else begin
                prev_lr = lr0;
                prev_rdy = rdy0;
            end
        end
        check_eq("frame_start_seen", found, 1'b1);
        check_eq("ready_before_load", prev_rdy, 1'b0);
        check_eq("ready_after_load", rdy0, 1'b1);
        wait_pos(4, 63, 400);
        check_eq("underrun_pulses_f4", ur_pulses, exp_underruns);

        // Reset at bit_cnt=10 with a held sample that must be discarded
        wait_pos(4, 3, 300);
        pkt0 = 16'hBEEF; v0 = 1'b1;
        tick(); v0 = 1'b0;
        wait_pos(4, 10, 100);
        check_eq("held_ready", rdy0, 1'b0);
        rst = 1'b1;
        tick();
        check_reset0("midrst");
        rst = 1'b0;
        wait_pos(5, 63, 400);
        check_eq("underrun_pulses_f5", ur_pulses, exp_underruns);
        check_eq("underrun_cycles_f5", ur_hi, exp_underruns);

        // BCLK_DIV=1 instance: 0x8001 serialization
        rst = 1'b1;
        tick(); tick();
        check_eq("rst1b_ready", rdy1, 1'b1);
        check_eq("rst1b_lrclk", lr1, 1'b0);
        check_eq("rst1b_sd", sd1, 1'b0);
        rst = 1'b0; pkt1 = 16'h8001; v1 = 1'b1;
        n1 = 0; bits1 = 0; b1prev = 1'b0; lr1_last = -1; lr1_per = 0;
        c1_sd = '0; c1_lr = '0; prev_lr = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 1) begin
                v1 = 1'b0;
                check_eq("div1_ready", rdy1, 1'b0);
            end
            if (c <= 4) check_eq("div1_bclk", bclk1, (c % 2 == 1) ? 1'b1 : 1'b0);
            if (bclk1 && !b1prev) begin
                n1++;
                if (n1 >= 2 && n1 <= FB + 1) begin
                    c1_sd[n1-2] = sd1;
                    c1_lr[n1-2] = lr1;
                    bits1++;
                end
            end
            if (lr1 && !prev_lr) begin
                if (lr1_last >= 0) lr1_per = c - lr1_last;
                lr1_last = c;
            end
            b1prev = bclk1;
            prev_lr = lr1;
        end
        check_eq("div1_bits", bits1, FB);
        check_eq("div1_frame_sd", c1_sd, frame_bits(16'h8001));
        check_eq("div1_frame_lrclk", c1_lr, {32'hFFFF_FFFF, 32'h0000_0000});
        check_eq("div1_lrclk_period", lr1_per, 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output-side audio transmitter for the DSP chain. It takes processed mono samples from the delay/chorus path and serializes them as a standard I2S stream (BCLK, LRCLK, SD) for the DAC.
- All timing is generated inside the single DSP clock domain (clk).
- A one-entry holding register with a valid/ready handshake decouples sample arrival from frame timing.

Parameters:
- PKT_WIDTH, 16, bits per audio sample; must be ≤ SLOT_WIDTH-1.
- SLOT_WIDTH, 32, BCLK periods per channel slot; one frame is 2*SLOT_WIDTH BCLK periods.
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be ≥ 1.

Ports:
- clk  input  1  system clock (CLK_DSP).
- rst  input  1  synchronous reset, active-high.
- pkt_i  input  PKT_WIDTH  signed sample to transmit.
- pkt_valid_i  input  1  pkt_i valid this cycle.
- pkt_ready_o  output  1  holding register empty; sample accepted when pkt_valid_i && pkt_ready_o.
- bclk_o  output  1  I2S bit clock.
- lrclk_o  output  1  I2S word select; 0 = left, 1 = right.
- sd_o  output  1  I2S serial data, MSB first.
- underrun_o  output  1  one-cycle pulse when a frame starts with no new sample.

Behaviour:
- Reset (rst=1 at posedge clk):
  - Outputs: bclk_o=0, lrclk_o=0, sd_o=0, underrun_o=0, pkt_ready_o=1.
  - Internal: div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, hold empty, shadow=0.
  - Reset mid-frame aborts the frame and discards any held sample. All registers take reset values on the next edge.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1; on terminal count it wraps and toggles bclk_o.
  - A "fall event" is the cycle in which bclk_o toggles 1→0. The first rise is BCLK_DIV cycles after reset release; the first fall is 2*BCLK_DIV cycles after.
- Bit counter:
  - bit_cnt, width $clog2(2*SLOT_WIDTH), advances by 1 on each fall event.
  - It wraps 2*SLOT_WIDTH-1→0; the wrap is the "frame start".
- Registered outputs, updated on each fall event using the new bit_cnt value k:
  - lrclk_o = (k ≥ SLOT_WIDTH).
  - Slot position p = k mod SLOT_WIDTH.
  - sd_o = shadow[PKT_WIDTH-p] for 1 ≤ p ≤ PKT_WIDTH, else 0. This gives the standard I2S one-BCLK delay after the LRCLK edge.
  - The same shadow sample is sent in both left and right slots (mono duplicate).
  - sd_o and lrclk_o change only on falling BCLK edges; the DAC samples on rising edges.
- Frame start (fall event where bit_cnt wraps to 0):
  - If hold is full: shadow ← hold, hold cleared.
  - If hold is empty: underrun_o pulses high for exactly that cycle, and shadow is handled per the Optional Feature.
  - Frame start evaluates hold state registered before the current cycle. A sample accepted in the frame-start cycle itself is held for the next frame, and that frame reports underrun.
- Handshake:
  - pkt_ready_o = !hold_full (registered).
  - On accept: hold ← pkt_i and hold_full ← 1, so ready falls the next cycle.
  - Ready returns to 1 the cycle after the frame-start load.
  - pkt_valid_i while ready=0 is ignored; there is no overwrite.
- Latency: the MSB of an accepted sample appears on sd_o at the fall event with bit_cnt=1 of the next frame start.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_MUTE_EN.
- Defined: on underrun, shadow ← 0, so a silent frame is transmitted.
- Undefined: on underrun, shadow keeps its previous value, so the last sample is repeated.
- underrun_o pulses identically in both builds.

Test Plan:
- Reset/timing (BCLK_DIV=2, SLOT_WIDTH=32) -> outputs at reset values; bclk_o rises 2 cycles and falls 4 cycles after reset release; bclk period 4 clk; lrclk period 256 clk.
- Accept 0xA5C3 before the first frame start -> left slot SD bits p=1..16 = 1010010111000011, p=0 and p=17..31 are 0; right slot identical; lrclk_o low for 32 BCLK, then high for 32.
- Two back-to-back valid samples 0x1234, 0x5678 -> first accepted, pkt_ready_o=0 and second ignored until frame start; ready=1 the cycle after load; 0x1234 transmitted.
- No sample for frame 2 after 0xA5C3 -> underrun_o one-cycle pulse at frame start; frame 2 sends 0xA5C3 (macro undefined) or all zeros (macro defined).
- Assert rst during bit_cnt=10 with hold full -> next edge all outputs at reset values, pkt_ready_o=1; the held sample is never transmitted.
- BCLK_DIV=1 -> bclk_o toggles every clk; frame = 128 clk; 0x8001 serializes correctly.
